// File: rtl/morse_keyer_if.sv
// Letter output bus of the Morse keyer front end, plus the raw key line feeding it.
// master = keyer side, slave = symbol decoder side (which also owns the key stimulus).
interface morse_keyer_if;
    logic       key_in;
    logic       sym_valid;
    logic [4:0] sym_bits;
    logic [2:0] sym_len;
    logic       sym_err;

    modport master (
        input  key_in,
        output sym_valid, sym_bits, sym_len, sym_err
    );

    modport slave (
        output key_in,
        input  sym_valid, sym_bits, sym_len, sym_err
    );
endinterface

// File: rtl/morse_keyer.sv
// Morse key front end: synchronise + debounce one key, time presses and gaps,
// and emit each letter as a left-aligned dot/dash word with an element count.
//
// state | meaning
// IDLE  | no letter in progress, waiting for a debounced press
// PRESS | key down, counting press length
// GAP   | key up after an element, counting toward letter end
// EMIT  | one cycle: publish the letter (or overflow error) and clear it
module morse_keyer #(
    parameter int DEBOUNCE_CYC = 16,
    parameter int DASH_CYC     = 300,
    parameter int GAP_CYC      = 600
) (
    input  logic          clk,
    input  logic          reset,
    morse_keyer_if.master bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int PR_W = $clog2(DASH_CYC + 1);
    localparam int GP_W = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q;
    logic            key_sync;
    logic            key_db;
    logic [DB_W-1:0] db_cnt;
    logic [PR_W-1:0] press_q, press_d;
    logic [GP_W-1:0] gap_q, gap_d;
    logic [4:0]      buf_q, buf_d;
    logic [2:0]      len_q, len_d;
    logic            ovf_q, ovf_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [4:0]      bits_q, bits_d;
    logic [2:0]      slen_q, slen_d;

    assign key_sync      = sync_q[1];
    assign bus.sym_valid = valid_q;
    assign bus.sym_err   = err_q;
    assign bus.sym_bits  = bits_q;
    assign bus.sym_len   = slen_q;

    // key_db only flips after DEBOUNCE_CYC consecutive cycles of disagreement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
            key_db <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.key_in};
            if (key_sync == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                key_db <= ~key_db;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            press_q <= '0;
            gap_q   <= '0;
            buf_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            bits_q  <= '0;
            slen_q  <= '0;
        end else begin
            state_q <= state_d;
            press_q <= press_d;
            gap_q   <= gap_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            bits_q  <= bits_d;
            slen_q  <= slen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        press_d = press_q;
        gap_d   = gap_q;
        buf_d   = buf_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        bits_d  = bits_q;
        slen_d  = slen_q;
        case (state_q)
            IDLE: begin
                if (key_db) begin
                    state_d = PRESS;
                    press_d = PR_W'(1);
                end
            end
            PRESS: begin
                if (key_db) begin
                    if (press_q != PR_W'(DASH_CYC))
                        press_d = press_q + PR_W'(1);
                end else begin
                    state_d = GAP;
                    gap_d   = GP_W'(1);
                    // a sixth element is dropped but poisons the whole letter
                    if (len_q < 3'd5) begin
                        buf_d[3'd4 - len_q] = (press_q >= PR_W'(DASH_CYC));
                        len_d = len_q + 3'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            GAP: begin
                if (key_db) begin
                    state_d = PRESS;
                    press_d = PR_W'(1);
                end else if (gap_q != GP_W'(GAP_CYC)) begin
                    gap_d = gap_q + GP_W'(1);
                    if (gap_q == GP_W'(GAP_CYC - 1))
                        state_d = EMIT;
                end
            end
            EMIT: begin
                if (ovf_q) begin
                    err_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    bits_d  = buf_q;
                    slen_d  = len_q;
                end
                buf_d   = '0;
                len_d   = '0;
                ovf_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: table of letters plus hand-written corner sequences,
// checked through an expected-letter queue against a negedge output monitor.
module tb_morse_keyer;
    localparam int DB   = 4;
    localparam int DASH = 10;
    localparam int GAP  = 20;
    // raw release -> sym_valid: 2 sync + debounce + gap + output register
    localparam int LAT  = 2 + DB + GAP + 1;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    morse_keyer_if bus ();

    morse_keyer #(.DEBOUNCE_CYC(DB), .DASH_CYC(DASH), .GAP_CYC(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct {
        logic       valid;
        logic       err;
        logic [4:0] bits;
        logic [2:0] len;
        int         cyc;
    } obs_t;

    typedef struct {
        int         n;
        int         p[6];
        int         g;
        logic       err;
        logic [4:0] bits;
        logic [2:0] len;
    } vec_t;

    obs_t obs_q[$];

    always @(negedge clk) begin
        if (!reset && (bus.sym_valid || bus.sym_err))
            obs_q.push_back('{valid: bus.sym_valid, err: bus.sym_err,
                              bits: bus.sym_bits, len: bus.sym_len, cyc: cyc});
    end

    int   errors = 0;
    int   checks = 0;
    int   rd = 0;
    int   last_rel = 0;
    obs_t exp_q[$];
    vec_t vt[7];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // all stimulus tasks start and end #1 after a rising edge
    task automatic press(input int p);
        bus.key_in = 1'b1;
        repeat (p) @(posedge clk);
        #1 bus.key_in = 1'b0;
        last_rel = cyc;
    endtask

    task automatic low(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_letter(input logic err, input logic [4:0] bits, input logic [2:0] len);
        exp_q.push_back('{valid: !err, err: err, bits: bits, len: len, cyc: last_rel + LAT});
    endtask

    task automatic drain(input string tag);
        obs_t e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd < obs_q.size()) begin
                o = obs_q[rd];
                rd++;
                chk({tag, " valid"}, int'(o.valid), int'(e.valid));
                chk({tag, " err"}, int'(o.err), int'(e.err));
                chk({tag, " bits"}, int'(o.bits), int'(e.bits));
                chk({tag, " len"}, int'(o.len), int'(e.len));
                chk({tag, " latency"}, o.cyc, e.cyc);
            end else begin
                chk({tag, " letter emitted"}, 0, 1);
            end
        end
        chk({tag, " no extra output"}, obs_q.size() - rd, 0);
        rd = obs_q.size();
    endtask

    initial begin
        vt[0] = '{1, '{5, 0, 0, 0, 0, 0}, 8, 1'b0, 5'b00000, 3'd1};    // E
        vt[1] = '{4, '{15, 5, 15, 5, 0, 0}, 8, 1'b0, 5'b10100, 3'd4};  // C
        vt[2] = '{2, '{10, 9, 0, 0, 0, 0}, 19, 1'b0, 5'b10000, 3'd2};  // N, dash/dot edges, 19-cycle gap
        vt[3] = '{6, '{5, 5, 5, 5, 5, 5}, 8, 1'b1, 5'b10000, 3'd2};    // overflow, outputs held
        vt[4] = '{1, '{15, 0, 0, 0, 0, 0}, 8, 1'b0, 5'b10000, 3'd1};   // T
        vt[5] = '{5, '{12, 5, 12, 5, 12, 0}, 8, 1'b0, 5'b10101, 3'd5}; // five elements
        vt[6] = '{2, '{9, 10, 0, 0, 0, 0}, 8, 1'b0, 5'b01000, 3'd2};   // A

        reset = 1'b1;
        bus.key_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        low(100);
        chk("idle bits", int'(bus.sym_bits), 0);
        chk("idle len", int'(bus.sym_len), 0);
        chk("idle no output", obs_q.size(), 0);
        rd = obs_q.size();

        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < vt[i].n; j++) begin
                press(vt[i].p[j]);
                if (j < vt[i].n - 1) low(vt[i].g);
            end
            expect_letter(vt[i].err, vt[i].bits, vt[i].len);
            low(40);
            drain($sformatf("vec%0d", i));
        end

        for (int k = 0; k < 3; k++) begin
            press(3);
            low(10);
        end
        low(40);
        chk("glitch no output", obs_q.size() - rd, 0);
        rd = obs_q.size();

        // 6 high, 3-cycle dropout, 6 high: one 15-cycle dash
        bus.key_in = 1'b1;
        low(6);
        bus.key_in = 1'b0;
        low(3);
        press(6);
        expect_letter(1'b0, 5'b10000, 3'd1);
        low(40);
        drain("dropout");

        bus.key_in = 1'b1;
        low(200);
        chk("held no output", obs_q.size() - rd, 0);
        bus.key_in = 1'b0;
        last_rel = cyc;
        expect_letter(1'b0, 5'b10000, 3'd1);
        low(40);
        drain("held");

        bus.key_in = 1'b1;
        low(12);
        #2 reset = 1'b1;
        #1;
        chk("reset bits", int'(bus.sym_bits), 0);
        chk("reset len", int'(bus.sym_len), 0);
        chk("reset valid", int'(bus.sym_valid), 0);
        bus.key_in = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        low(60);
        chk("post reset no output", obs_q.size() - rd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
